// File: rtl/an_dec_scheduler_pkg.sv
// Shared constants, status codes and FSM state type for the AN-code decoder scheduler.
package an_dec_pkg;
   localparam int A      = 13837;
   localparam int W_BITS = 39;
   localparam int N_BITS = 25;

   localparam logic [1:0] ST_CLEAN = 2'b00;
   localparam logic [1:0] ST_CORR  = 2'b01;
   localparam logic [1:0] ST_TMO   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_t;
endpackage

// File: rtl/an_dec_scheduler_if.sv
// Requester, response and decoder-side signals of the scheduler; slave is the scheduler view.
interface an_dec_scheduler_if #(
   parameter int NREQ    = 4,
   parameter int ID_BITS = 2,
   parameter int W_BITS  = an_dec_pkg::W_BITS,
   parameter int N_BITS  = an_dec_pkg::N_BITS
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*W_BITS-1:0] req_w;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_BITS-1:0]     rsp_id;
   logic [N_BITS-1:0]      rsp_n;
   logic [1:0]             rsp_status;
   logic                   dec_start;
   logic [W_BITS-1:0]      dec_w;
   logic                   dec_abort;
   logic                   dec_done;
   logic [N_BITS-1:0]      dec_n;
   logic                   dec_corrected;

   modport master (
      output req_valid, req_w, rsp_ready, dec_done, dec_n, dec_corrected,
      input  req_ready, rsp_valid, rsp_id, rsp_n, rsp_status, dec_start, dec_w, dec_abort
   );

   modport slave (
      input  req_valid, req_w, rsp_ready, dec_done, dec_n, dec_corrected,
      output req_ready, rsp_valid, rsp_id, rsp_n, rsp_status, dec_start, dec_w, dec_abort
   );
endinterface

// File: rtl/an_dec_scheduler_rr_arbiter.sv
// Combinational rotate-priority select: first valid requester at or after ptr, wrapping.
module an_rr_arbiter #(
   parameter int NREQ    = 4,
   parameter int ID_BITS = 2
) (
   input  logic [NREQ-1:0]    req_valid,
   input  logic [ID_BITS-1:0] ptr,
   output logic [NREQ-1:0]    grant_oh,
   output logic [ID_BITS-1:0] grant_idx,
   output logic               any_valid
);
   logic [ID_BITS-1:0] idx_s;

   function automatic logic [ID_BITS-1:0] wrap_idx(input logic [ID_BITS:0] v);
      logic [ID_BITS:0] r;
      r = (v >= (ID_BITS+1)'(NREQ)) ? (v - (ID_BITS+1)'(NREQ)) : v;
      return r[ID_BITS-1:0];
   endfunction

   assign any_valid = |req_valid;

   // Scan from the farthest offset down so the offset nearest ptr takes priority.
   always_comb begin
      idx_s     = '0;
      grant_idx = '0;
      grant_oh  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx_s     = wrap_idx({1'b0, ptr} + (ID_BITS+1)'(k));
         grant_idx = req_valid[idx_s] ? idx_s : grant_idx;
      end
      grant_oh[grant_idx] = any_valid;
   end
endmodule

// File: rtl/an_dec_scheduler.sv
// Shares one multi-cycle AN-code SEC decoder between NREQ requesters with round-robin
// arbitration, a WAIT-state watchdog and a single id-tagged response channel.
module an_dec_scheduler #(
   parameter int NREQ     = 4,
   parameter int ID_BITS  = 2,
   parameter int W_BITS   = an_dec_pkg::W_BITS,
   parameter int N_BITS   = an_dec_pkg::N_BITS,
   parameter int TIMEOUT  = 96,
   parameter int TMR_BITS = 7
) (
   input  logic               clk,
   input  logic               rst,
   an_dec_scheduler_if.slave  bus
);
   import an_dec_pkg::*;

   state_t              state_r, state_nx_s;
   logic [ID_BITS-1:0]  ptr_r;
   logic [ID_BITS-1:0]  grant_idx_s;
   logic [NREQ-1:0]     grant_oh_s;
   logic                any_valid_s;
   logic                timeout_s;
   logic [TMR_BITS-1:0] timer_r;
   logic [W_BITS-1:0]   dec_w_r;
   logic [ID_BITS-1:0]  rsp_id_r;
   logic [N_BITS-1:0]   rsp_n_r;
   logic [1:0]          rsp_status_r;
   logic                dec_abort_r;

   an_rr_arbiter #(.NREQ(NREQ), .ID_BITS(ID_BITS)) u_arb (
      .req_valid (bus.req_valid),
      .ptr       (ptr_r),
      .grant_oh  (grant_oh_s),
      .grant_idx (grant_idx_s),
      .any_valid (any_valid_s)
   );

   assign timeout_s = (timer_r == TMR_BITS'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; dec_done is only observed in WAIT and beats the timeout.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         S_IDLE:  state_nx_s = any_valid_s ? S_ISSUE : S_IDLE;
         S_ISSUE: state_nx_s = S_WAIT;
         S_WAIT:  state_nx_s = (bus.dec_done || timeout_s) ? S_RESP : S_WAIT;
         S_RESP:  state_nx_s = bus.rsp_ready ? S_IDLE : S_RESP;
         default: state_nx_s = S_IDLE;
      endcase
   end

   // State-decoded handshake outputs.
   always_comb begin
      bus.req_ready = '0;
      bus.dec_start = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state_r)
         S_IDLE:  bus.req_ready = grant_oh_s;
         S_ISSUE: bus.dec_start = 1'b1;
         S_WAIT:  bus.dec_start = 1'b0;
         S_RESP:  bus.rsp_valid = 1'b1;
         default: bus.req_ready = '0;
      endcase
   end

   // Datapath: codeword/id capture, watchdog, result capture and pointer advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r        <= '0;
         timer_r      <= '0;
         dec_w_r      <= '0;
         rsp_id_r     <= '0;
         rsp_n_r      <= '0;
         rsp_status_r <= ST_CLEAN;
         dec_abort_r  <= 1'b0;
      end else begin
         dec_abort_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (any_valid_s) begin
                  dec_w_r  <= bus.req_w[grant_idx_s * W_BITS +: W_BITS];
                  rsp_id_r <= grant_idx_s;
               end
            end
            S_ISSUE: timer_r <= '0;
            S_WAIT: begin
               timer_r <= timer_r + TMR_BITS'(1);
               if (bus.dec_done) begin
                  rsp_n_r      <= bus.dec_n;
                  rsp_status_r <= bus.dec_corrected ? ST_CORR : ST_CLEAN;
               end else if (timeout_s) begin
                  rsp_n_r      <= '0;
                  rsp_status_r <= ST_TMO;
                  dec_abort_r  <= 1'b1;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  ptr_r <= (rsp_id_r == ID_BITS'(NREQ - 1)) ? '0 : rsp_id_r + ID_BITS'(1);
               end
            end
            default: timer_r <= '0;
         endcase
      end
   end

   assign bus.dec_w      = dec_w_r;
   assign bus.rsp_id     = rsp_id_r;
   assign bus.rsp_n      = rsp_n_r;
   assign bus.rsp_status = rsp_status_r;
   assign bus.dec_abort  = dec_abort_r;
endmodule
